float_mul_stream: RTL

// - Parametrised, stallable IEEE-754-style floating-point multiplier; successor to the fixed-latency FP multipliers.
// - Adds valid/ready flow control, round-to-nearest-even, special-value handling and per-result exception flags.
// - Sits between operand producers (IIR/ALU datapath) and a result consumer that may apply backpressure.

---
 rtl/fp_pkg.sv | 44 ++++
 rtl/fp_round_pack.sv | 63 ++++++
 rtl/float_mul_stream.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the streaming FP multiplier: operand classes,
// flag bit positions and width-generic constant helpers.
package fp_pkg;

  localparam int MAX_W = 64;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_cls_e;

  function automatic int bias_of(input int we);
    return (1 << (we - 1)) - 1;
  endfunction

  function automatic int exp_max_of(input int we);
    return (1 << we) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [MAX_W-1:0] qnan_of(input int we, input int wm);
    logic [MAX_W-1:0] q;
    q = '0;
    for (int i = 0; i < we; i++) q[wm+i] = 1'b1;
    q[wm-1] = 1'b1;
    return q;
  endfunction

  // Denormals (exp == 0) classify as zero, flushing them to a signed zero.
  function automatic fp_cls_e classify(input logic exp_zero, input logic exp_ones,
                                       input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Rounds a normalised mantissa with guard/sticky bits and packs the result,
// resolving special classes and exponent overflow/underflow.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int WIDTH_exp = 8,
  parameter int WIDTH_mat = 23,
  parameter int ROUND_RNE = 1
) (
  input  logic                        sign,
  input  fp_cls_e                     cls,
  input  logic                        invalid_in,
  input  logic [WIDTH_mat:0]          mant,
  input  logic                        guard,
  input  logic                        sticky,
  input  logic signed [WIDTH_exp+1:0] exp_in,
  output logic [WIDTH-1:0]            word,
  output logic [3:0]                  flags
);

  localparam int EW = WIDTH_exp + 2;
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'(exp_max_of(WIDTH_exp));
  localparam logic [MAX_W-1:0] QNAN_W = qnan_of(WIDTH_exp, WIDTH_mat);

  logic                   round_up;
  logic                   carry;
  logic [WIDTH_mat+1:0]   mant_r;
  logic signed [EW-1:0]   exp_r;

  always_comb begin
    round_up = (ROUND_RNE != 0) && guard && (sticky || mant[0]);
    mant_r   = {1'b0, mant} + {{(WIDTH_mat+1){1'b0}}, round_up};
    // A carry out leaves the fraction bits all zero, so only the exponent moves.
    carry    = mant_r[WIDTH_mat+1];
    exp_r    = exp_in + $signed({{(EW-1){1'b0}}, carry});
    word     = '0;
    flags    = '0;
    case (cls)
      CLS_NAN: begin
        word                = QNAN_W[WIDTH-1:0];
        flags[FLAG_INVALID] = invalid_in;
      end
      CLS_INF:  word = {sign, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}};
      CLS_ZERO: word = {sign, {(WIDTH-1){1'b0}}};
      default: begin
        flags[FLAG_INEXACT] = guard | sticky;
        if (exp_r >= EXP_MAX_S) begin
          word                 = {sign, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}};
          flags[FLAG_OVERFLOW] = 1'b1;
          flags[FLAG_INEXACT]  = 1'b1;
        end else if (exp_r <= 0) begin
          word                  = {sign, {(WIDTH-1){1'b0}}};
          flags[FLAG_UNDERFLOW] = 1'b1;
          flags[FLAG_INEXACT]   = 1'b1;
        end else begin
          word = {sign, exp_r[WIDTH_exp-1:0], mant_r[WIDTH_mat-1:0]};
        end
      end
    endcase
  end

endmodule

// File: rtl/float_mul_stream.sv
// Three-stage stallable floating-point multiplier with valid/ready flow
// control: classify+multiply, normalise, round/pack into the output regs.
module float_mul_stream
  import fp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int WIDTH_exp = 8,
  parameter int WIDTH_mat = 23,
  parameter int ROUND_RNE = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic             exce_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             exce_out
);

  localparam int WE = WIDTH_exp;
  localparam int WM = WIDTH_mat;
  localparam int MW = WM + 1;
  localparam int PW = 2 * MW;
  localparam int EW = WE + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'(bias_of(WE));

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic          s_a, s_b;
  logic [WE-1:0] e_a, e_b;
  logic [WM-1:0] f_a, f_b;
  assign {s_a, e_a, f_a} = OP1;
  assign {s_b, e_b, f_b} = OP2;

  fp_cls_e              c_a, c_b, c_p;
  logic                 inv_p;
  logic [PW-1:0]        prod_c;
  logic signed [EW-1:0] exp_c;

  always_comb begin
    c_a   = classify(e_a == '0, &e_a, f_a == '0);
    c_b   = classify(e_b == '0, &e_b, f_b == '0);
    inv_p = 1'b0;
    if (c_a == CLS_NAN || c_b == CLS_NAN) begin
      c_p = CLS_NAN;
    end else if ((c_a == CLS_INF && c_b == CLS_ZERO) || (c_a == CLS_ZERO && c_b == CLS_INF)) begin
      c_p   = CLS_NAN;
      inv_p = 1'b1;
    end else if (c_a == CLS_INF || c_b == CLS_INF) begin
      c_p = CLS_INF;
    end else if (c_a == CLS_ZERO || c_b == CLS_ZERO) begin
      c_p = CLS_ZERO;
    end else begin
      c_p = CLS_NORM;
    end
  end

  assign prod_c = {{MW{1'b0}}, 1'b1, f_a} * {{MW{1'b0}}, 1'b1, f_b};
  assign exp_c  = $signed({2'b00, e_a}) + $signed({2'b00, e_b}) - BIAS_S;

  logic                 s1_valid, s1_sign, s1_inv, s1_exce;
  fp_cls_e              s1_cls;
  logic [PW-1:0]        s1_prod;
  logic signed [EW-1:0] s1_exp;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_inv   <= 1'b0;
      s1_exce  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_prod  <= '0;
      s1_exp   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sign  <= s_a ^ s_b;
      s1_inv   <= inv_p;
      s1_exce  <= exce_in;
      s1_cls   <= c_p;
      s1_prod  <= prod_c;
      s1_exp   <= exp_c;
    end
  end

  // Product of two [1,2) mantissas lies in [1,4); the top bit selects the shift.
  logic                 hi;
  logic [MW-1:0]        n_mant;
  logic                 n_g, n_s;
  logic signed [EW-1:0] n_exp;

  always_comb begin
    hi     = s1_prod[PW-1];
    n_mant = hi ? s1_prod[PW-1 -: MW] : s1_prod[PW-2 -: MW];
    n_g    = hi ? s1_prod[PW-1-MW] : s1_prod[PW-2-MW];
    n_s    = hi ? |s1_prod[PW-2-MW:0] : |s1_prod[PW-3-MW:0];
    n_exp  = s1_exp + $signed({{(EW-1){1'b0}}, hi});
  end

  logic                 s2_valid, s2_sign, s2_inv, s2_exce, s2_g, s2_s;
  fp_cls_e              s2_cls;
  logic [MW-1:0]        s2_mant;
  logic signed [EW-1:0] s2_exp;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_inv   <= 1'b0;
      s2_exce  <= 1'b0;
      s2_g     <= 1'b0;
      s2_s     <= 1'b0;
      s2_cls   <= CLS_ZERO;
      s2_mant  <= '0;
      s2_exp   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_inv   <= s1_inv;
      s2_exce  <= s1_exce;
      s2_g     <= n_g;
      s2_s     <= n_s;
      s2_cls   <= s1_cls;
      s2_mant  <= n_mant;
      s2_exp   <= n_exp;
    end
  end

  logic [WIDTH-1:0] rp_word;
  logic [3:0]       rp_flags;

  fp_round_pack #(
    .WIDTH     (WIDTH),
    .WIDTH_exp (WIDTH_exp),
    .WIDTH_mat (WIDTH_mat),
    .ROUND_RNE (ROUND_RNE)
  ) u_round_pack (
    .sign       (s2_sign),
    .cls        (s2_cls),
    .invalid_in (s2_inv),
    .mant       (s2_mant),
    .guard      (s2_g),
    .sticky     (s2_s),
    .exp_in     (s2_exp),
    .word       (rp_word),
    .flags      (rp_flags)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      exce_out  <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result   <= rp_word;
        flags    <= rp_flags;
        exce_out <= s2_exce | rp_flags[FLAG_INVALID] | rp_flags[FLAG_OVERFLOW]
                    | rp_flags[FLAG_UNDERFLOW];
      end else begin
        result   <= '0;
        flags    <= '0;
        exce_out <= 1'b0;
      end
    end
  end

endmodule
